// File: rtl/pose_uart_tx.sv
// Per-frame pose reporter: snapshots the analyser outputs at each frame boundary and
// transmits them as a 10-byte XOR-checksummed packet on an 8N1 UART line.
module pose_uart_tx #(
    parameter int unsigned BAUD_DIV = 217
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_frm,
    input  logic [11:0] centre_pos_x,
    input  logic [11:0] centre_pos_y,
    input  logic [9:0]  angle_x,
    input  logic [9:0]  angle_y,
    input  logic        chieu_xoay,
    output logic        tx,
    output logic        busy,
    output logic        frm_dropped
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state;
    logic          f1;
    logic          f2;
    logic          frm_edge;
    logic [CW-1:0] baud_cnt;
    logic          baud_tick;
    logic [2:0]    bit_idx;
    logic [2:0]    next_bit;
    logic [3:0]    byte_idx;

    logic [11:0]   snap_cx;
    logic [11:0]   snap_cy;
    logic [9:0]    snap_ax;
    logic [9:0]    snap_ay;
    logic          snap_cw;

    logic [7:0]    b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic [7:0]    pkt_byte;

    // Same detector as the analyser, so the inputs still hold the finished frame here.
    assign frm_edge  = f1 & ~f2;
    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign next_bit  = bit_idx + 3'd1;

    assign b1 = {4'h0, snap_cx[11:8]};
    assign b2 = snap_cx[7:0];
    assign b3 = {4'h0, snap_cy[11:8]};
    assign b4 = snap_cy[7:0];
    assign b5 = {snap_cw, 5'b0, snap_ax[9:8]};
    assign b6 = snap_ax[7:0];
    assign b7 = {6'b0, snap_ay[9:8]};
    assign b8 = snap_ay[7:0];
    assign b9 = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ b7 ^ b8;

    always_comb begin
        pkt_byte = 8'hAA;
        case (byte_idx)
            4'd0:    pkt_byte = 8'hAA;
            4'd1:    pkt_byte = b1;
            4'd2:    pkt_byte = b2;
            4'd3:    pkt_byte = b3;
            4'd4:    pkt_byte = b4;
            4'd5:    pkt_byte = b5;
            4'd6:    pkt_byte = b6;
            4'd7:    pkt_byte = b7;
            4'd8:    pkt_byte = b8;
            4'd9:    pkt_byte = b9;
            default: pkt_byte = 8'hAA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1          <= 1'b0;
            f2          <= 1'b0;
            state       <= S_IDLE;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frm_dropped <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            snap_cx     <= '0;
            snap_cy     <= '0;
            snap_ax     <= '0;
            snap_ay     <= '0;
            snap_cw     <= 1'b0;
        end else begin
            f1          <= new_frm;
            f2          <= f1;
            frm_dropped <= frm_edge && (state != S_IDLE);

            if (state == S_IDLE || baud_tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    if (frm_edge) begin
                        snap_cx <= centre_pos_x;
                        snap_cy <= centre_pos_y;
                        snap_ax <= angle_x;
                        snap_ay <= angle_y;
                        snap_cw <= chieu_xoay;
                        state   <= S_START;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= pkt_byte[0];
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= pkt_byte[next_bit];
                        end
                    end
                end
                S_STOP: begin
                    // The final stop bit is still part of the packet; busy drops only after it.
                    if (baud_tick) begin
                        if (byte_idx < 4'd9) begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= S_START;
                            tx       <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pose_uart_tx.sv
// Bench for pose_uart_tx: directed frames, expected bytes queued at stimulus time and
// checked by an independent UART receiver process.
module tb_pose_uart_tx;

    localparam int DIV_A = 4;
    localparam int DIV_B = 217;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_frm_a;
    logic        new_frm_b;
    logic [11:0] cx;
    logic [11:0] cy;
    logic [9:0]  ax;
    logic [9:0]  ay;
    logic        cw;
    logic        tx_a, busy_a, drop_a;
    logic        tx_b, busy_b, drop_b;

    always #5 clk = ~clk;

    pose_uart_tx #(.BAUD_DIV(DIV_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .new_frm(new_frm_a),
        .centre_pos_x(cx), .centre_pos_y(cy), .angle_x(ax), .angle_y(ay), .chieu_xoay(cw),
        .tx(tx_a), .busy(busy_a), .frm_dropped(drop_a)
    );

    pose_uart_tx #(.BAUD_DIV(DIV_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .new_frm(new_frm_b),
        .centre_pos_x(cx), .centre_pos_y(cy), .angle_x(ax), .angle_y(ay), .chieu_xoay(cw),
        .tx(tx_b), .busy(busy_b), .frm_dropped(drop_b)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    logic [11:0] in_cx [3] = '{12'h5A3, 12'hFFF, 12'h123};
    logic [11:0] in_cy [3] = '{12'h1F0, 12'h000, 12'h456};
    logic [9:0]  in_ax [3] = '{10'h2C7, 10'h3FF, 10'h1AB};
    logic [9:0]  in_ay [3] = '{10'h135, 10'h200, 10'h3CD};
    logic        in_cw [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  vec [3][10] = '{
        '{8'hAA, 8'h05, 8'hA3, 8'h01, 8'hF0, 8'h82, 8'hC7, 8'h01, 8'h35, 8'h26},
        '{8'hAA, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h03, 8'hFF, 8'h02, 8'h00, 8'h0E},
        '{8'hAA, 8'h01, 8'h23, 8'h04, 8'h56, 8'h81, 8'hAB, 8'h03, 8'hCD, 8'h94}
    };

    logic mon_sel = 1'b0;
    logic mon_tx;
    logic mon_busy;
    int   mon_div;
    assign mon_tx   = mon_sel ? tx_b : tx_a;
    assign mon_busy = mon_sel ? busy_b : busy_a;
    assign mon_div  = mon_sel ? DIV_B : DIV_A;

    int bytes_seen = 0;
    int busy_run   = 0;
    int last_run   = 0;
    int drop_hi    = 0;
    int drop_rise  = 0;
    logic drop_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: samples every cycle so any bit of the wrong width breaks framing.
    initial begin
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst_n && mon_tx == 1'b0) begin
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int c = 0; c < mon_div; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[k] = mon_tx;
                        else if (mon_tx !== bits[k]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    check("frame start/stop/stable", {29'd0, bits[9], bits[0], stable}, 3'b101);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected byte: got %0h expected none", bits[8:1]);
                    end else begin
                        check("byte", bits[8:1], exp_q.pop_front());
                    end
                    bytes_seen++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_busy) begin
            busy_run = busy_run + 1;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (drop_a) drop_hi = drop_hi + 1;
        if (drop_a && !drop_prev) drop_rise = drop_rise + 1;
        drop_prev = drop_a;
    end

    task automatic load(input int vi);
        cx = in_cx[vi];
        cy = in_cy[vi];
        ax = in_ax[vi];
        ay = in_ay[vi];
        cw = in_cw[vi];
        for (int i = 0; i < 10; i++) exp_q.push_back(vec[vi][i]);
    endtask

    task automatic fire_a();
        @(posedge clk);
        #1 new_frm_a = 1'b1;
    endtask

    task automatic wait_busy(input string name);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!mon_busy && guard < 20);
        if (!mon_busy) begin
            total++;
            bad++;
            $display("FAIL %s busy rise: got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name, input int div);
        int guard;
        guard = 0;
        while (mon_busy && guard < 100 * div + 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (mon_busy) begin
            total++;
            bad++;
            $display("FAIL %s busy fall: timeout after %0d cycles", name, guard);
        end
        check({name, " busy length"}, last_run, 100 * div);
        check({name, " tx idle"}, int'(mon_tx), 1);
        check({name, " queue drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int bad_cycles;
        int d_rise;
        int d_hi;
        int seen0;

        rst_n = 1'b0;
        new_frm_a = 1'b0;
        new_frm_b = 1'b0;
        cx = '0; cy = '0; ax = '0; ay = '0; cw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx/busy/drop", {tx_a, busy_a, drop_a}, 3'b100);
        rst_n = 1'b1;

        // Idle line with no frame marker.
        bad_cycles = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({tx_a, busy_a, drop_a} !== 3'b100) bad_cycles++;
        end
        check("idle 1000 cycles bad count", bad_cycles, 0);

        // Single packet, reference vector.
        load(0);
        fire_a();
        wait_busy("t2");
        wait_idle("t2", DIV_A);
        new_frm_a = 1'b0;

        // Inputs cleared one cycle after capture: stream must not change.
        repeat (5) @(negedge clk);
        load(0);
        fire_a();
        wait_busy("t3");
        cx = '0; cy = '0; ax = '0; ay = '0; cw = 1'b0;
        wait_idle("t3", DIV_A);
        new_frm_a = 1'b0;

        // Frame edge mid-packet is dropped; edge right after busy falls is accepted.
        repeat (5) @(negedge clk);
        d_rise = drop_rise;
        d_hi   = drop_hi;
        load(1);
        fire_a();
        wait_busy("t4a");
        repeat (20) @(negedge clk);
        new_frm_a = 1'b0;
        repeat (30) @(negedge clk);
        new_frm_a = 1'b1;
        repeat (10) @(negedge clk);
        new_frm_a = 1'b0;
        check("t4 drop pulses", drop_rise - d_rise, 1);
        check("t4 drop high cycles", drop_hi - d_hi, 1);
        wait_idle("t4a", DIV_A);
        load(0);
        new_frm_a = 1'b1;
        wait_busy("t4b");
        wait_idle("t4b", DIV_A);
        check("t4 total drop pulses", drop_rise - d_rise, 1);

        // Asynchronous reset during byte 3, then a fresh packet.
        new_frm_a = 1'b0;
        repeat (5) @(negedge clk);
        load(0);
        fire_a();
        wait_busy("t5a");
        repeat (3 * 10 * DIV_A + 15) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        new_frm_a = 1'b0;
        #1;
        check("t5 async reset tx/busy", {tx_a, busy_a}, 2'b10);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        seen0 = bytes_seen;
        load(1);
        fire_a();
        wait_busy("t5b");
        wait_idle("t5b", DIV_A);
        check("t5 bytes after reset", bytes_seen - seen0, 10);
        new_frm_a = 1'b0;

        // Full-rate divider on the second instance.
        repeat (5) @(negedge clk);
        mon_sel = 1'b1;
        repeat (2) @(negedge clk);
        load(2);
        @(posedge clk);
        #1 new_frm_b = 1'b1;
        wait_busy("t6");
        wait_idle("t6", DIV_B);
        new_frm_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
